// File: rtl/instruction_fetch.sv
// instruction_fetch: holds the fetch PC, keeps at most one instruction-memory read in flight,
// and queues returned words with their PCs in a 2-entry buffer feeding the decoder.
module instruction_fetch #(
    parameter int unsigned    bus      = 32,
    parameter logic [bus-1:0] RESET_PC = '0,
    parameter logic [bus-1:0] PC_STEP  = bus'(4)
) (
    input  logic           clk,
    input  logic           rst,
    output logic           imem_req,
    output logic [bus-1:0] imem_addr,
    input  logic           imem_rvalid,
    input  logic [31:0]    imem_rdata,
    input  logic           branch_taken,
    input  logic [bus-1:0] branch_target,
    output logic           instr_valid,
    output logic [31:0]    instr,
    output logic [bus-1:0] instr_pc,
    input  logic           instr_ready
);

    // StWait keeps the outstanding response, StDrop throws it away after a redirect.
    typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

    state_e         r_state;
    state_e         w_state_next;
    logic [bus-1:0] r_fetch_pc;
    logic [bus-1:0] w_fetch_pc_next;
    logic [bus-1:0] r_req_pc;
    logic [1:0]     r_count;
    logic [1:0]     w_count_next;
    logic [2:0]     w_level;
    logic           w_push;
    logic           w_pop;
    logic           w_issue;
    logic [31:0]    r_instr0;
    logic [31:0]    r_instr1;
    logic [bus-1:0] r_pc0;
    logic [bus-1:0] r_pc1;

    // A redirect suppresses both buffer updates in its cycle.
    assign w_push  = imem_rvalid && (r_state == StWait) && !branch_taken;
    assign w_pop   = instr_valid && instr_ready && !branch_taken;
    // Occupancy after this cycle's push/pop; an issue is allowed only if a slot stays free.
    assign w_level = {1'b0, r_count} + {2'b00, w_push} - {2'b00, w_pop};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a redirect wins over a simultaneous response or issue.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_issue) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (branch_taken) begin
                    w_state_next = imem_rvalid ? StIdle : StDrop;
                end else if (imem_rvalid) begin
                    w_state_next = w_issue ? StWait : StIdle;
                end
            end
            StDrop: begin
                if (imem_rvalid) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Issue decision; a response landing in StDrop never chains a new request.
    always_comb begin
        w_issue = !rst && !branch_taken && (w_level < 3'd2) &&
                  ((r_state == StIdle) || ((r_state == StWait) && imem_rvalid));
        imem_req = w_issue;
    end

    // Next fetch PC and buffer occupancy.
    always_comb begin
        w_fetch_pc_next = r_fetch_pc;
        if (branch_taken) begin
            w_fetch_pc_next = branch_target;
        end else if (w_issue) begin
            w_fetch_pc_next = r_fetch_pc + PC_STEP;
        end
        w_count_next = branch_taken ? 2'd0 : w_level[1:0];
    end

    // Fetch PC, PC of the request in flight, and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_count    <= 2'd0;
        end else begin
            r_fetch_pc <= w_fetch_pc_next;
            r_count    <= w_count_next;
            if (w_issue) begin
                r_req_pc <= r_fetch_pc;
            end
        end
    end

    // Buffer storage: slot 0 is the head; slots only move on pop so the head holds when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr0 <= '0;
            r_pc0    <= '0;
            r_instr1 <= '0;
            r_pc1    <= '0;
        end else begin
            if (w_pop && (r_count == 2'd2)) begin
                r_instr0 <= r_instr1;
                r_pc0    <= r_pc1;
            end
            if (w_push) begin
                if (w_level == 3'd1) begin
                    r_instr0 <= imem_rdata;
                    r_pc0    <= r_req_pc;
                end else begin
                    r_instr1 <= imem_rdata;
                    r_pc1    <= r_req_pc;
                end
            end
        end
    end

    assign imem_addr   = r_fetch_pc;
    assign instr_valid = (r_count != 2'd0);
    assign instr       = r_instr0;
    assign instr_pc    = r_pc0;

endmodule
